// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, byte-addressed, big-endian data memory
// between the CPU load/store port (m0) and a DMA/debug port (m1).
// Each access takes IDLE -> ACCESS -> RESP, and every output is registered.
// The memory is expected to register its read data on the edge that ends ACCESS.
// Optional build macro: DMEM_ALIGN_CHECK_EN. When it is defined, misaligned or
// out-of-range commands are granted, skip the memory strobe and complete with err=1.
module dmem_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   cap_we;
  logic   cap_id;
  logic   cap_bad;
  logic   last;     // id of the requester served most recently

  logic              sel_valid;
  logic              sel_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_bad;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam logic [ADDR_W:0] MAX_ADDR = (ADDR_W+1)'((2**ADDR_W) - 4);
`endif

  // Pick a winner among the live requests and check its command.
  always_comb begin
    sel_valid = m0_req | m1_req;
    if (m0_req && m1_req) begin
      sel_id = (ROUND_ROBIN != 0) ? ~last : 1'b0;
    end else begin
      sel_id = m1_req;
    end
    sel_we    = sel_id ? m1_we    : m0_we;
    sel_addr  = sel_id ? m1_addr  : m0_addr;
    sel_wdata = sel_id ? m1_wdata : m0_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
    sel_bad = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} > MAX_ADDR);
`else
    sel_bad = 1'b0;
`endif
  end

`ifndef DMEM_ALIGN_CHECK_EN
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  // Access sequencer: pulses default low each cycle, set only in their state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_we    <= 1'b0;
      cap_id    <= 1'b0;
      cap_bad   <= 1'b0;
      last      <= 1'b1;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
`endif
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (sel_valid) begin
            cap_we    <= sel_we;
            cap_id    <= sel_id;
            cap_bad   <= sel_bad;
            last      <= sel_id;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            m0_gnt    <= ~sel_id;
            m1_gnt    <= sel_id;
            if (sel_bad) begin
              state <= RESP;
            end else begin
              mem_write <= sel_we;
              mem_read  <= ~sel_we;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          state <= RESP;
        end
        RESP: begin
          m0_done <= ~cap_id;
          m1_done <= cap_id;
          if (!cap_bad && !cap_we) begin
            if (cap_id) m1_rdata <= mem_rdata;
            else        m0_rdata <= mem_rdata;
          end
`ifdef DMEM_ALIGN_CHECK_EN
          m0_err <= cap_bad & ~cap_id;
          m1_err <= cap_bad & cap_id;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a scoreboard of
// expected completions. A second instance with ROUND_ROBIN=0 shares the
// requester inputs and is used only to observe its grant pattern.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [9:0]  m0_addr = 0, m1_addr = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  logic        b_m0_gnt, b_m0_done, b_m0_err, b_m1_gnt, b_m1_done, b_m1_err;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_wdata;
  logic [9:0]  b_mem_addr;
  logic        b_mem_write, b_mem_read;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .ROUND_ROBIN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .ROUND_ROBIN(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_write(b_mem_write),
    .mem_read(b_mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory with a registered read port, big-endian bytes.
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr]        <= mem_wdata[31:24];
      mem[mem_addr + 10'd1] <= mem_wdata[23:16];
      mem[mem_addr + 10'd2] <= mem_wdata[15:8];
      mem[mem_addr + 10'd3] <= mem_wdata[7:0];
    end
    if (mem_read)
      mem_rdata <= {mem[mem_addr], mem[mem_addr + 10'd1],
                    mem[mem_addr + 10'd2], mem[mem_addr + 10'd3]};
  end

  // Reference byte memory and last-returned read data per requester.
  logic [7:0]  ref_mem [1024];
  logic [31:0] shadow_rd [2];

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on port id; called at a negedge with DUT in IDLE.
  task automatic xfer(input bit id, input bit we, input logic [9:0] addr, input logic [31:0] wd);
    bit   bad;
    exp_t e;
    exp_t got;
    int   a;
    bad = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    bad = (addr[1:0] != 2'b00) || (addr > 10'd1020);
`endif
    if (id == 1'b0) begin
      m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end
    a = int'(addr);
    e.id = id;
    e.err = bad;
    if (!bad && we) begin
      ref_mem[a] = wd[31:24]; ref_mem[(a+1)%1024] = wd[23:16];
      ref_mem[(a+2)%1024] = wd[15:8]; ref_mem[(a+3)%1024] = wd[7:0];
    end
    if (!bad && !we)
      shadow_rd[id] = {ref_mem[a], ref_mem[(a+1)%1024], ref_mem[(a+2)%1024], ref_mem[(a+3)%1024]};
    e.rdata = shadow_rd[id];
    sb.push_back(e);

    @(negedge clk);
    chk("gnt_winner", id ? m1_gnt : m0_gnt, 1);
    chk("gnt_other", id ? m0_gnt : m1_gnt, 0);
    m0_req = 0; m1_req = 0;
    if (!bad) begin
      chk("strobe_access", {mem_write, mem_read}, {we, ~we});
      chk("mem_addr", mem_addr, addr);
      if (we) chk("mem_wdata", mem_wdata, wd);
      @(negedge clk);
      chk("strobe_resp", {mem_write, mem_read}, 0);
      chk("done_early", {m1_done, m0_done}, 0);
    end else begin
      chk("strobe_bad", {mem_write, mem_read}, 0);
    end
    @(negedge clk);
    chk("done_winner", id ? m1_done : m0_done, 1);
    chk("done_other", id ? m0_done : m1_done, 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      chk("rdata", got.id ? m1_rdata : m0_rdata, got.rdata);
      chk("err", got.id ? m1_err : m0_err, {31'b0, got.err});
    end
    $display("xfer id=%0d we=%0d addr=%0d wdata=%h -> m0_rdata=%h m1_rdata=%h",
             id, we, addr, wd, m0_rdata, m1_rdata);
  endtask

  initial begin
    int rr0_m0, rr0_m1;
    bit found;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    shadow_rd[0] = 0; shadow_rd[1] = 0;

    // Reset held with both requests high.
    m0_req = 1; m1_req = 1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {m1_gnt, m0_gnt, b_m1_gnt, b_m0_gnt}, 0);
    chk("rst_done", {m1_done, m0_done, m1_err, m0_err}, 0);
    chk("rst_strobe", {mem_write, mem_read}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", m0_rdata | m1_rdata | mem_wdata, 0);
    rst_n = 1;
    xfer(0, 0, 10'd0, 32'h0);

    // Store then load on m0.
    xfer(0, 1, 10'd8, 32'hDEADBEEF);
    xfer(0, 0, 10'd8, 32'h0);
    xfer(0, 1, 10'd16, 32'h11111111);
    xfer(0, 0, 10'd16, 32'h0);

    // m1 traffic must leave m0's result alone.
    xfer(1, 1, 10'd12, 32'hCAFEF00D);
    xfer(1, 0, 10'd12, 32'h0);
    chk("m0_rdata_held", m0_rdata, 32'h11111111);

    // Continuous contention; m1 was served last so m0 goes first.
    m0_req = 1; m0_we = 0; m0_addr = 10'd8;
    m1_req = 1; m1_we = 0; m1_addr = 10'd12;
    rr0_m0 = 0; rr0_m1 = 0;
    for (int g = 0; g < 4; g++) begin
      found = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (b_m0_gnt) rr0_m0++;
        if (b_m1_gnt) rr0_m1++;
        if (m0_gnt || m1_gnt) begin
          found = 1;
          chk("rr_order", {31'b0, m1_gnt}, g % 2);
          $display("contention grant %0d -> m%0d", g, m1_gnt);
          break;
        end
      end
      if (!found) chk("rr_timeout", 0, 1);
    end
    m0_req = 0; m1_req = 0;
    chk("prio_m1_never", rr0_m1, 0);
    chk("prio_m0_count", rr0_m0, 4);
    repeat (2) @(negedge clk);

    // Reset during the ACCESS cycle of a store.
    m0_req = 1; m0_we = 1; m0_addr = 10'd20; m0_wdata = 32'h55555555;
    @(negedge clk);
    chk("abort_pre_write", mem_write, 1);
    rst_n = 0;
    #1;
    chk("abort_write_drop", mem_write, 0);
    m0_req = 0;
    @(negedge clk);
    rst_n = 1;
    shadow_rd[0] = 0; shadow_rd[1] = 0;
    chk("abort_rdata_cleared", m0_rdata, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_done", {m1_done, m0_done}, 0);
    end
    $display("reset abort checked");
    xfer(0, 0, 10'd20, 32'h0);

    // Misaligned store on m1, read-back, top aligned word.
    xfer(1, 1, 10'd6, 32'hA5A5A5A5);
    xfer(1, 0, 10'd4, 32'h0);
    xfer(1, 0, 10'd8, 32'h0);
    xfer(0, 1, 10'd1020, 32'h01020304);
    xfer(0, 0, 10'd1020, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    xfer(0, 0, 10'd1022, 32'h0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
